// File: rtl/if_stage.sv
// Instruction fetch stage: owns fetch_pc, issues imem word requests, buffers
// returned words and presents the head entry to decode; drops stale fetches after a redirect.
//
// state | meaning
// RUN   | issue fetches while buffer + in-flight space remains
// DRAIN | redirect pending: no fetches, drop responses until discard == 0
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter int          MAX_OUTST  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ID_stall,
    input  logic        EX_redirect,
    input  logic [31:0] EX_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_pc,
    output logic [31:0] IF_inst,
    output logic        IF_vld
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic ST_RUN   = 1'b0;
    localparam logic ST_DRAIN = 1'b1;

    logic          state;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] outst;
    logic [CW-1:0] discard;
    logic [CW-1:0] fifo_cnt;
    logic [PW-1:0] fifo_rd;
    logic [PW-1:0] fifo_wr;
    logic [31:0]   fifo_pc   [FIFO_DEPTH];
    logic [31:0]   fifo_inst [FIFO_DEPTH];
    logic [TW-1:0] tag_rd;
    logic [TW-1:0] tag_wr;
    logic [31:0]   tag_pc    [MAX_OUTST];

    logic          req_fire;
    logic          resp_fire;
    logic          push;
    logic          pop;
    logic [CW:0]   space_used;
    logic [CW-1:0] outst_nxt;
    logic [CW-1:0] discard_dec;
    logic          unused_tgt_lsb;

    assign unused_tgt_lsb = ^EX_target[1:0];

    function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
        return (p == TW'(MAX_OUTST - 1)) ? '0 : p + TW'(1);
    endfunction

    // Space is reserved for every in-flight request, so a response always has a slot.
    assign space_used = {1'b0, fifo_cnt} + {1'b0, outst};

    assign imem_req = !rst && (state == ST_RUN) && !EX_redirect
                      && (space_used < (CW+1)'(FIFO_DEPTH))
                      && (outst < CW'(MAX_OUTST));
    assign imem_addr = fetch_pc;

    assign req_fire    = imem_req && imem_gnt;
    assign resp_fire   = !rst && imem_rvalid && (outst != '0);
    assign push        = resp_fire && (discard == '0) && !EX_redirect;
    assign pop         = IF_vld && !ID_stall && !EX_redirect;
    assign outst_nxt   = outst + CW'(req_fire) - CW'(resp_fire);
    assign discard_dec = (resp_fire && discard != '0) ? discard - CW'(1) : discard;

    assign IF_vld  = !rst && (fifo_cnt != '0);
    assign IF_pc   = IF_vld ? fifo_pc[fifo_rd]   : 32'h0;
    assign IF_inst = IF_vld ? fifo_inst[fifo_rd] : NOP;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            fetch_pc <= RESET_PC;
            outst    <= '0;
            discard  <= '0;
            fifo_cnt <= '0;
            fifo_rd  <= '0;
            fifo_wr  <= '0;
            tag_rd   <= '0;
            tag_wr   <= '0;
        end else begin
            outst <= outst_nxt;
            if (req_fire)  tag_wr <= tag_inc(tag_wr);
            if (resp_fire) tag_rd <= tag_inc(tag_rd);

            if (EX_redirect) begin
                fetch_pc <= {EX_target[31:2], 2'b00};
                discard  <= outst_nxt;
                state    <= (outst_nxt != '0) ? ST_DRAIN : ST_RUN;
                fifo_cnt <= '0;
                fifo_rd  <= '0;
                fifo_wr  <= '0;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + 32'd4;
                discard <= discard_dec;
                if (state == ST_DRAIN && discard_dec == '0) state <= ST_RUN;
                if (push) fifo_wr <= fifo_wr + PW'(1);
                if (pop)  fifo_rd <= fifo_rd + PW'(1);
                fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage needs no reset: validity is carried by the counters and pointers.
    always_ff @(posedge clk) begin
        if (req_fire) tag_pc[tag_wr] <= fetch_pc;
        if (push) begin
            fifo_pc[fifo_wr]   <= tag_pc[tag_rd];
            fifo_inst[fifo_wr] <= imem_rdata;
        end
    end

    assert property (@(posedge clk) disable iff (rst) imem_rvalid |-> (outst != '0))
        else $error("if_stage: imem_rvalid with no request outstanding");

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: in-order imem model with 1-cycle response latency,
// consumed-PC sequence tracking, stall / redirect / grant-hold / reset scenarios.
module tb_if_stage;
    localparam logic [31:0] RPC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst;
    logic        ID_stall;
    logic        EX_redirect;
    logic [31:0] EX_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] IF_pc;
    logic [31:0] IF_inst;
    logic        IF_vld;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_cons = 0;
    int          c0;
    int          waited;
    bit          resp_en = 1'b1;
    bit          chk_seq = 1'b0;
    logic [31:0] exp_pc;
    logic [31:0] hp;
    logic [31:0] hi;
    logic [31:0] pend[$];

    if_stage #(.RESET_PC(RPC), .FIFO_DEPTH(2), .MAX_OUTST(2)) dut (
        .clk(clk), .rst(rst), .ID_stall(ID_stall), .EX_redirect(EX_redirect),
        .EX_target(EX_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .IF_pc(IF_pc), .IF_inst(IF_inst), .IF_vld(IF_vld)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] img(input logic [31:0] a);
        return a ^ 32'h5A3C_0F01;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One clock cycle: drive the memory response, track consumption, record the grant.
    task automatic step();
        logic        fire;
        logic [31:0] a;
        if (resp_en && pend.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = img(pend.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        #1;
        fire = imem_req && imem_gnt;
        a    = imem_addr;
        if (chk_seq && IF_vld && !ID_stall && !EX_redirect && !rst) begin
            chk("seq_pc", IF_pc, exp_pc);
            chk("seq_inst", IF_inst, img(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_cons++;
        end
        @(posedge clk);
        if (fire) pend.push_back(a);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ID_stall = 1'b0; EX_redirect = 1'b0; EX_target = 32'h0;
        imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        @(negedge clk);
        step(); step();
        chk("rst_req", imem_req, 0);
        chk("rst_vld", IF_vld, 0);
        chk("rst_pc", IF_pc, 32'h0);
        chk("rst_inst", IF_inst, 32'h0000_0013);

        // 1: free-running fetch from RESET_PC, wrapping through 0x0
        rst = 1'b0;
        #1;
        chk("post_rst_vld", IF_vld, 0);
        chk("post_rst_pc", IF_pc, 32'h0);
        chk("post_rst_req", imem_req, 1);
        chk("post_rst_addr", imem_addr, RPC);
        exp_pc  = RPC;
        chk_seq = 1'b1;
        repeat (15) step();
        chk("t1_count", 32'(n_cons >= 8), 1);

        // 2: decode stall freezes the head and fills the buffer
        ID_stall = 1'b1;
        repeat (2) step();
        hp = IF_pc; hi = IF_inst;
        chk("t2_head", hp, exp_pc);
        repeat (3) step();
        chk("t2_pc_frozen", IF_pc, hp);
        chk("t2_inst_frozen", IF_inst, hi);
        chk("t2_vld", IF_vld, 1);
        chk("t2_req_full", imem_req, 0);
        ID_stall = 1'b0;
        repeat (8) step();

        // 3: redirect with two requests in flight
        resp_en = 1'b0;
        repeat (4) step();
        chk("t3_outst", pend.size(), 2);
        chk("t3_vld", IF_vld, 0);
        EX_redirect = 1'b1; EX_target = 32'h0000_0103;
        #1;
        chk("t3_req_on_redir", imem_req, 0);
        step();
        EX_redirect = 1'b0;
        exp_pc  = 32'h0000_0100;
        resp_en = 1'b1;
        #1;
        chk("t3_drain_req", imem_req, 0);
        waited = 0;
        while (!imem_req && waited < 10) begin
            step();
            waited++;
        end
        chk("t3_wait", waited, 2);
        chk("t3_addr", imem_addr, 32'h0000_0100);
        repeat (8) step();

        // 4: redirect while stalled with a full buffer
        ID_stall = 1'b1;
        repeat (5) step();
        chk("t4_vld_full", IF_vld, 1);
        chk("t4_req_full", imem_req, 0);
        EX_redirect = 1'b1; EX_target = 32'h0000_0200;
        step();
        EX_redirect = 1'b0;
        exp_pc = 32'h0000_0200;
        #1;
        chk("t4_vld_flushed", IF_vld, 0);
        chk("t4_req", imem_req, 1);
        chk("t4_addr", imem_addr, 32'h0000_0200);
        repeat (3) step();
        chk("t4_head", IF_pc, 32'h0000_0200);
        ID_stall = 1'b0;
        repeat (8) step();

        // 5: grant withheld -> request and address held steady
        imem_gnt = 1'b0;
        repeat (3) step();
        chk("t5_vld", IF_vld, 0);
        chk("t5_addr0", imem_addr, exp_pc);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_req_hold", imem_req, 1);
            chk("t5_addr_hold", imem_addr, exp_pc);
        end
        imem_gnt = 1'b1;
        repeat (8) step();

        // 6: reset with requests in flight; their responses never arrive
        resp_en = 1'b0;
        repeat (4) step();
        chk("t6_outst", pend.size(), 2);
        rst = 1'b1;
        step(); step();
        pend.delete();
        chk("t6_rst_req", imem_req, 0);
        chk("t6_rst_vld", IF_vld, 0);
        rst = 1'b0;
        resp_en = 1'b1;
        exp_pc = RPC;
        #1;
        chk("t6_vld", IF_vld, 0);
        chk("t6_req", imem_req, 1);
        chk("t6_addr", imem_addr, RPC);
        c0 = n_cons;
        repeat (10) step();
        chk("t6_count", 32'((n_cons - c0) >= 5), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
